icu_sequencer: RTL and testbench

ICU_SEQUENCER -- requirements
Module: icu_sequencer

---
 rtl/icu_sequencer.sv | 86 ++++++++
 tb/tb_icu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icu_sequencer.sv
// Program sequencer for a one-bit ICU: PC, operand register, output latch and bit-addressed I/O.
// Optional return stack is enabled by defining RET_STACK_EN; the default build returns to 8'h00.
module icu_sequencer (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       icu_state,
    input  logic       JMP,
    input  logic       RTN,
    input  logic       write,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [3:0] I,
    input  logic       icu_data_i,
    output logic       icu_data_o,
    output logic       icu_data_oe,
    input  logic [7:0] in_port,
    output logic [7:0] out_port
);

    logic [7:0] pc;
    logic [7:0] pc_next;
    logic [3:0] opr;
    logic [7:0] out_q;
    logic [7:0] ret_addr;

`ifdef RET_STACK_EN
    logic [7:0] stack_q [4];
    logic [1:0] sp;
    logic [1:0] sp_prev;

    assign sp_prev  = sp - 2'd1;
    assign ret_addr = stack_q[sp_prev];

    // Circular stack: pushes overwrite the oldest entry, pops on empty wrap and return stale data.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sp <= 2'd0;
            // NOTE: the entries are cleared as well, so a pop before any push returns 8'h00.
            for (int i = 0; i < 4; i++) begin
                stack_q[i] <= 8'h00;
            end
        end else if (!icu_state) begin
            if (JMP) begin
                stack_q[sp] <= pc;
                sp          <= sp + 2'd1;
            end else if (RTN) begin
                sp <= sp_prev;
            end
        end
    end
`else
    assign ret_addr = 8'h00;
`endif

    // NOTE: every path assigns pc_next after its default, so no latch can be inferred.
    always_comb begin
        pc_next = pc + 8'd1;
        if (JMP) begin
            pc_next = {opr, 4'h0};
        end else if (RTN) begin
            pc_next = ret_addr;
        end
    end

    // JMP/RTN/write belong to the word fetched last time, so they act with the old opr.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            pc    <= 8'h00;
            opr   <= 4'h0;
            out_q <= 8'h00;
        end else if (!icu_state) begin
            pc  <= pc_next;
            opr <= rom_data[3:0];
            if (write && opr[3]) begin
                out_q[opr[2:0]] <= icu_data_i;
            end
        end
    end

    assign rom_addr    = pc;
    assign out_port    = out_q;
    assign I           = JMP ? 4'b0000 : rom_data[7:4];
    assign icu_data_o  = opr[3] ? out_q[opr[2:0]] : in_port[opr[2:0]];
    assign icu_data_oe = ~write;

endmodule

// File: tb/tb_icu_sequencer.sv
// Directed bench for icu_sequencer; the bench plays the ICU and holds the program ROM.
// Stack scenarios are compiled only when RET_STACK_EN is defined.
module tb_icu_sequencer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       icu_state;
    logic       JMP;
    logic       RTN;
    logic       write;
    logic       icu_data_i;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic [3:0] I;
    logic       icu_data_o;
    logic       icu_data_oe;

    logic [7:0] rom [256];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_in = ~clk_in;

    assign rom_data = rom[rom_addr];

    icu_sequencer dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .icu_state   (icu_state),
        .JMP         (JMP),
        .RTN         (RTN),
        .write       (write),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .I           (I),
        .icu_data_i  (icu_data_i),
        .icu_data_o  (icu_data_o),
        .icu_data_oe (icu_data_oe),
        .in_port     (in_port),
        .out_port    (out_port)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic st, input logic jmp, input logic rtn,
                         input logic wr, input logic din);
        icu_state  = st;
        JMP        = jmp;
        RTN        = rtn;
        write      = wr;
        icu_data_i = din;
        #1;
    endtask

    task automatic fetch(input logic jmp, input logic rtn, input logic wr, input logic din);
        drive(1'b0, jmp, rtn, wr, din);
        tick();
    endtask

    task automatic execute();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            fetch(1'b0, 1'b0, 1'b0, 1'b0);
            execute();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0]  = 8'h19;
        in_port = 8'h01;
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h00) $display("FAIL reset_pc: got %h want %h", rom_addr, 8'h00); else n_pass++;
        n_total++; if (out_port !== 8'h00) $display("FAIL reset_out: got %h want %h", out_port, 8'h00); else n_pass++;
        n_total++; if (icu_data_o !== 1'b1) $display("FAIL reset_opr_read: got %b want %b", icu_data_o, 1'b1); else n_pass++;
        n_total++; if (I !== 4'h1) $display("FAIL reset_opcode: got %h want %h", I, 4'h1); else n_pass++;
        n_total++; if (icu_data_oe !== 1'b1) $display("FAIL reset_oe: got %b want %b", icu_data_oe, 1'b1); else n_pass++;
    endtask

    task automatic test_sequence();
        clear_rom();
        rom[0] = 8'h19; rom[1] = 8'h88; rom[2] = 8'h00; rom[3] = 8'h00;
        in_port = 8'hFF;
        do_reset();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h01) $display("FAIL seq_pc1: got %h want %h", rom_addr, 8'h01); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (icu_data_o !== 1'b0) $display("FAIL seq_ld_out1: got %b want %b", icu_data_o, 1'b0); else n_pass++;
        tick();
        n_total++; if (rom_addr !== 8'h01) $display("FAIL seq_hold: got %h want %h", rom_addr, 8'h01); else n_pass++;
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h02) $display("FAIL seq_pc2: got %h want %h", rom_addr, 8'h02); else n_pass++;
        execute();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (icu_data_oe !== 1'b0) $display("FAIL seq_oe_write: got %b want %b", icu_data_oe, 1'b0); else n_pass++;
        tick();
        n_total++; if (rom_addr !== 8'h03) $display("FAIL seq_pc3: got %h want %h", rom_addr, 8'h03); else n_pass++;
        n_total++; if (out_port !== 8'h00) $display("FAIL seq_out: got %h want %h", out_port, 8'h00); else n_pass++;
    endtask

    task automatic test_load_store();
        clear_rom();
        rom[0] = 8'h12; rom[1] = 8'h88; rom[2] = 8'h18; rom[3] = 8'h83; rom[4] = 8'h8F;
        in_port = 8'h04;
        do_reset();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (icu_data_o !== 1'b1) $display("FAIL ld_in2: got %b want %b", icu_data_o, 1'b1); else n_pass++;
        tick();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b0, 1'b0, 1'b1, 1'b1);
        n_total++; if (out_port !== 8'h01) $display("FAIL sto_out0: got %h want %h", out_port, 8'h01); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (icu_data_o !== 1'b1) $display("FAIL ld_out0: got %b want %b", icu_data_o, 1'b1); else n_pass++;
        tick();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b0, 1'b0, 1'b1, 1'b1);
        n_total++; if (out_port !== 8'h01) $display("FAIL sto_input_ignored: got %h want %h", out_port, 8'h01); else n_pass++;
        execute();
        fetch(1'b0, 1'b0, 1'b1, 1'b1);
        n_total++; if (out_port !== 8'h81) $display("FAIL sto_out7: got %h want %h", out_port, 8'h81); else n_pass++;
    endtask

    task automatic test_jump();
        clear_rom();
        rom[5] = 8'hC3; rom[6] = 8'h77; rom[8'h30] = 8'h5A;
        do_reset();
        advance(5);
        n_total++; if (rom_addr !== 8'h05) $display("FAIL jmp_reach: got %h want %h", rom_addr, 8'h05); else n_pass++;
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++; if (I !== 4'h0) $display("FAIL jmp_bubble: got %h want %h", I, 4'h0); else n_pass++;
        tick();
        n_total++; if (rom_addr !== 8'h30) $display("FAIL jmp_target: got %h want %h", rom_addr, 8'h30); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (I !== 4'h5) $display("FAIL jmp_after_opcode: got %h want %h", I, 4'h5); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0] = 8'hCF;
        do_reset();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b1, 1'b0, 1'b0, 1'b0);
        execute();
        advance(15);
        n_total++; if (rom_addr !== 8'hFF) $display("FAIL wrap_top: got %h want %h", rom_addr, 8'hFF); else n_pass++;
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h00) $display("FAIL wrap_zero: got %h want %h", rom_addr, 8'h00); else n_pass++;
    endtask

    task automatic test_jmp_rtn_priority();
        clear_rom();
        rom[0] = 8'hC2;
        do_reset();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b1, 1'b1, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h20) $display("FAIL jmp_over_rtn: got %h want %h", rom_addr, 8'h20); else n_pass++;
    endtask

`ifdef RET_STACK_EN
    task automatic test_return();
        clear_rom();
        rom[5] = 8'hC3; rom[8'h32] = 8'hD0;
        do_reset();
        advance(5);
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b1, 1'b0, 1'b0, 1'b0);
        execute();
        advance(3);
        fetch(1'b0, 1'b1, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h06) $display("FAIL rtn_pop: got %h want %h", rom_addr, 8'h06); else n_pass++;
        execute();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h07) $display("FAIL rtn_skip: got %h want %h", rom_addr, 8'h07); else n_pass++;
    endtask

    task automatic test_stack_wrap();
        logic [7:0] want [5];
        clear_rom();
        rom[5] = 8'hC1; rom[8'h10] = 8'hC2; rom[8'h20] = 8'hC3; rom[8'h30] = 8'hC3;
        do_reset();
        advance(5);
        // Pushes 06, 11, 21, 31, 31; the fifth overwrites 06.
        repeat (5) begin
            fetch(1'b0, 1'b0, 1'b0, 1'b0);
            execute();
            fetch(1'b1, 1'b0, 1'b0, 1'b0);
            execute();
        end
        want[0] = 8'h31; want[1] = 8'h31; want[2] = 8'h21; want[3] = 8'h11; want[4] = 8'h31;
        for (int k = 0; k < 5; k++) begin
            fetch(1'b0, 1'b1, 1'b0, 1'b0);
            n_total++; if (rom_addr !== want[k]) $display("FAIL stack_pop%0d: got %h want %h", k + 1, rom_addr, want[k]); else n_pass++;
            execute();
        end
    endtask
`else
    task automatic test_return();
        clear_rom();
        rom[0] = 8'hC2;
        do_reset();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b1, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h21) $display("FAIL rtn_setup: got %h want %h", rom_addr, 8'h21); else n_pass++;
        execute();
        fetch(1'b0, 1'b1, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h00) $display("FAIL rtn_zero: got %h want %h", rom_addr, 8'h00); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_jump();
        clear_rom();
        rom[0] = 8'h88; rom[1] = 8'hC4;
        do_reset();
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        execute();
        fetch(1'b0, 1'b0, 1'b1, 1'b1);
        n_total++; if (out_port !== 8'h01) $display("FAIL midjmp_setup: got %h want %h", out_port, 8'h01); else n_pass++;
        execute();
        rst = 1'b0;
        fetch(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        n_total++; if (rom_addr !== 8'h00) $display("FAIL midjmp_pc: got %h want %h", rom_addr, 8'h00); else n_pass++;
        n_total++; if (out_port !== 8'h00) $display("FAIL midjmp_out: got %h want %h", out_port, 8'h00); else n_pass++;
        fetch(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (rom_addr !== 8'h01) $display("FAIL post_reset_fetch: got %h want %h", rom_addr, 8'h01); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        in_port = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_sequence();
        test_load_store();
        test_jump();
        test_wrap();
        test_jmp_rtn_priority();
        test_return();
`ifdef RET_STACK_EN
        test_stack_wrap();
`endif
        test_reset_mid_jump();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
